// File: rtl/id_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: RV32I opcodes, immediate
// formats and the control half of the ID/EX slot.
package id_issue_stage_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_e;

  // Control fields of the ID/EX slot; the XLEN-wide datapath values live
  // beside it in the stage so the width stays a module parameter.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] funct7_60;
    logic       branch;
    logic       csr_op;
    logic       use_f7;
    logic       use_reg_add;
    logic [4:0] rd;
    logic       reg_write;
    logic       illegal;
  } id_ex_t;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      STORE:       fmt = ImmS;
      BRANCH:      fmt = ImmB;
      LUI, AUIPC:  fmt = ImmU;
      JAL:         fmt = ImmJ;
      default:     fmt = ImmI;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/id_issue_stage_imm_gen.sv
// Combinational RV32I immediate generator, sign-extended to XLEN.
module id_issue_stage_imm_gen
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Reassemble the scattered immediate bits for the selected format
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      ImmI: imm32 = {{20{instr[31]}}, instr[31:20]};
      ImmS: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU: imm32 = {instr[31:12], 12'b0};
      ImmJ: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes the fetched instruction, checks the register
// scoreboard for RAW/WAW hazards and loads one registered ID/EX slot.
// Optional feature: define ID_WB_BYPASS_EN to let a same-cycle writeback
// clear the hazard and forward wbData into the operands.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            idValid,
  output logic            idReady,
  input  logic [31:0]     idInstr,
  input  logic [XLEN-1:0] idPc,
  output logic [4:0]      rs1Addr,
  output logic [4:0]      rs2Addr,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  output logic            exValid,
  input  logic            exReady,
  output logic [XLEN-1:0] exPc,
  output logic [2:0]      funct3,
  output logic [1:0]      funct7_60,
  output logic            branch,
  output logic            csrOp,
  output logic            useF7,
  output logic            useRegAdd,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [4:0]      exRd,
  output logic            exRegWrite,
  output logic [XLEN-1:0] exTarget,
  output logic            exIllegal,
  input  logic            wbValid,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  input  logic            flush
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode  = idInstr[6:0];
  assign rd      = idInstr[11:7];
  assign f3      = idInstr[14:12];
  assign rs1     = idInstr[19:15];
  assign rs2     = idInstr[24:20];
  assign rs1Addr = rs1;
  assign rs2Addr = rs2;

  logic is_op, is_op_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_system, illegal;
  logic rs1_used, rs2_used, reg_write;

  // Opcode classification and register usage
  always_comb begin
    is_op     = (opcode == OP);
    is_op_imm = (opcode == OP_IMM);
    is_load   = (opcode == LOAD);
    is_store  = (opcode == STORE);
    is_branch = (opcode == BRANCH);
    is_jal    = (opcode == JAL);
    is_jalr   = (opcode == JALR);
    is_lui    = (opcode == LUI);
    is_auipc  = (opcode == AUIPC);
    is_system = (opcode == SYSTEM);
    illegal   = ~(is_op | is_op_imm | is_load | is_store | is_branch |
                  is_jal | is_jalr | is_lui | is_auipc | is_system);
    rs1_used  = ~(is_lui | is_auipc | is_jal);
    rs2_used  = is_op | is_store | is_branch;
    // Illegal instructions still issue so EX can trap, but never write rd
    reg_write = (rd != 5'd0) & ~illegal & ~is_store & ~is_branch;
  end

  // Scoreboard and optional writeback bypass
  logic [NREGS-1:0] pending_q, pending_d, pending_eff, wb_mask;
  logic [XLEN-1:0]  rs1_val, rs2_val;

  // One-hot of the register retiring this cycle
  always_comb begin
    wb_mask = '0;
    if (wbValid) wb_mask[wbRd] = 1'b1;
  end

`ifdef ID_WB_BYPASS_EN
  assign pending_eff = pending_q & ~wb_mask;
  assign rs1_val = (wbValid && wbRd == rs1 && rs1 != 5'd0) ? wbData : rs1Data;
  assign rs2_val = (wbValid && wbRd == rs2 && rs2 != 5'd0) ? wbData : rs2Data;
`else
  assign pending_eff = pending_q;
  assign rs1_val = rs1Data;
  assign rs2_val = rs2Data;
  logic unused_wb_data;
  assign unused_wb_data = ^wbData;
`endif

  logic hazard, advance, issue, valid_q;

  assign hazard  = (rs1_used & pending_eff[rs1]) | (rs2_used & pending_eff[rs2]) |
                   (reg_write & pending_eff[rd]);
  assign advance = ~valid_q | exReady;
  assign issue   = idValid & advance & ~hazard & ~flush;
  // Held low during reset so fetch re-presents once the stage is live
  assign idReady = rstN & advance & (flush | ~hazard);

  // Operand and target selection
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm, src_a, src_b, target;

  assign fmt = imm_fmt(opcode);

  id_issue_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (idInstr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  // ALU operands and control-transfer target for the decoded instruction
  always_comb begin
    if (is_auipc | is_jal | is_jalr) src_a = idPc;
    else if (is_lui)                 src_a = '0;
    else                             src_a = rs1_val;

    if (is_jal | is_jalr)        src_b = XLEN'(4);
    else if (is_op | is_branch)  src_b = rs2_val;
    else                         src_b = imm;

    if (is_branch | is_jal) target = idPc + imm;
    else if (is_jalr)       target = (rs1_val + imm) & ~XLEN'(1);
    else                    target = '0;
  end

  id_ex_t dec;

  // Control fields destined for the slot
  always_comb begin
    dec             = '0;
    dec.funct3      = (is_lui | is_auipc | is_jal) ? 3'b000 : f3;
    dec.funct7_60   = {idInstr[30], idInstr[25]};
    dec.branch      = is_branch;
    dec.csr_op      = is_system & (f3 != 3'b000);
    dec.use_f7      = is_op | (is_op_imm & (f3 == 3'b101));
    dec.use_reg_add = is_load | is_store | is_jal | is_jalr | is_auipc | is_lui;
    dec.rd          = rd;
    dec.reg_write   = reg_write;
    dec.illegal     = illegal;
  end

  // ID/EX slot next state: load on issue, bubble on advance without issue
  id_ex_t          slot_q, slot_d;
  logic            valid_d;
  logic [XLEN-1:0] pc_q, pc_d, src_a_q, src_a_d, src_b_q, src_b_d, target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    slot_d   = slot_q;
    pc_d     = pc_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    target_d = target_q;
    if (advance) begin
      valid_d = issue;
      if (issue) begin
        slot_d   = dec;
        pc_d     = idPc;
        src_a_d  = src_a;
        src_b_d  = src_b;
        target_d = target;
      end else begin
        slot_d   = '0;
        pc_d     = '0;
        src_a_d  = '0;
        src_b_d  = '0;
        target_d = '0;
      end
    end
  end

  // Scoreboard next state: issue sets after writeback clears, so set wins
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (issue && reg_write) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Slot and scoreboard registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q   <= 1'b0;
      slot_q    <= '0;
      pc_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      target_q  <= '0;
      pending_q <= '0;
    end else begin
      valid_q   <= valid_d;
      slot_q    <= slot_d;
      pc_q      <= pc_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      target_q  <= target_d;
      pending_q <= pending_d;
    end
  end

  assign exValid    = valid_q;
  assign exPc       = pc_q;
  assign funct3     = slot_q.funct3;
  assign funct7_60  = slot_q.funct7_60;
  assign branch     = slot_q.branch;
  assign csrOp      = slot_q.csr_op;
  assign useF7      = slot_q.use_f7;
  assign useRegAdd  = slot_q.use_reg_add;
  assign srcA       = src_a_q;
  assign srcB       = src_b_q;
  assign exRd       = slot_q.rd;
  assign exRegWrite = slot_q.reg_write;
  assign exTarget   = target_q;
  assign exIllegal  = slot_q.illegal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: directed scenarios followed by a
// randomized run against a behavioural decode/scoreboard model.
module tb_id_issue_stage;

  localparam int unsigned XLEN = 32;

  logic            clk, rstN, idValid, idReady, exValid, exReady;
  logic [31:0]     idInstr;
  logic [XLEN-1:0] idPc, rs1Data, rs2Data, exPc, srcA, srcB, exTarget, wbData;
  logic [4:0]      rs1Addr, rs2Addr, exRd, wbRd;
  logic [2:0]      funct3;
  logic [1:0]      funct7_60;
  logic            branch, csrOp, useF7, useRegAdd, exRegWrite, exIllegal, wbValid, flush;

  int checks = 0;
  int errors = 0;

  id_issue_stage #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rstN(rstN), .idValid(idValid), .idReady(idReady), .idInstr(idInstr),
    .idPc(idPc), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .exValid(exValid), .exReady(exReady), .exPc(exPc), .funct3(funct3), .funct7_60(funct7_60),
    .branch(branch), .csrOp(csrOp), .useF7(useF7), .useRegAdd(useRegAdd), .srcA(srcA),
    .srcB(srcB), .exRd(exRd), .exRegWrite(exRegWrite), .exTarget(exTarget),
    .exIllegal(exIllegal), .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] target;
    logic [2:0]  funct3;
    logic [1:0]  f7;
    logic        branch;
    logic        csr;
    logic        use_f7;
    logic        use_add;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } slot_t;

  // Reference decode straight from the RV32I field definitions
  function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     output slot_t s, output bit u1, output bit u2);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    bit wr;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    s = '0;
    s.pc = pc;
    s.rd = i[11:7];
    s.f7 = {i[30], i[25]};
    s.funct3 = i[14:12];
    u1 = 1; u2 = 0; wr = 1;
    case (i[6:0])
      7'h33: begin s.use_f7 = 1; s.src_a = r1; s.src_b = r2; u2 = 1; end
      7'h13: begin s.use_f7 = (i[14:12] == 3'd5); s.src_a = r1; s.src_b = imm_i; end
      7'h03: begin s.use_add = 1; s.src_a = r1; s.src_b = imm_i; end
      7'h23: begin s.use_add = 1; s.src_a = r1; s.src_b = imm_s; u2 = 1; wr = 0; end
      7'h63: begin s.branch = 1; s.src_a = r1; s.src_b = r2; u2 = 1; wr = 0; s.target = pc + imm_b; end
      7'h6F: begin s.use_add = 1; s.src_a = pc; s.src_b = 4; s.funct3 = 0; u1 = 0; s.target = pc + imm_j; end
      7'h67: begin s.use_add = 1; s.src_a = pc; s.src_b = 4; s.target = (r1 + imm_i) & ~32'd1; end
      7'h37: begin s.use_add = 1; s.src_a = 0; s.src_b = imm_u; s.funct3 = 0; u1 = 0; end
      7'h17: begin s.use_add = 1; s.src_a = pc; s.src_b = imm_u; s.funct3 = 0; u1 = 0; end
      7'h73: begin s.csr = (i[14:12] != 0); s.src_a = r1; s.src_b = imm_i; end
      default: begin s.illegal = 1; wr = 0; s.src_a = r1; s.src_b = imm_i; end
    endcase
    s.reg_write = wr && (s.rd != 0);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] o;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: o = 7'h33; 1: o = 7'h13; 2: o = 7'h03; 3: o = 7'h23; 4: o = 7'h63;
      5: o = 7'h6F; 6: o = 7'h67; 7: o = 7'h37; 8: o = 7'h17; 9: o = 7'h73;
      default: o = 7'h7F;
    endcase
    r[6:0]   = o;
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idValid = 0; flush = 0; wbValid = 0; wbRd = 0; wbData = 0; exReady = 1;
    idInstr = 0; idPc = 0; rs1Data = 0; rs2Data = 0;
    rstN = 0;
    tick();
    rstN = 1;
    tick();
  endtask

  task automatic test_reset();
    idValid = 0; flush = 0; wbValid = 0; wbRd = 0; wbData = 0; exReady = 1;
    idInstr = 0; idPc = 0; rs1Data = 0; rs2Data = 0;
    rstN = 1;
    #1 rstN = 0;
    #1;
    checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL rst_exvalid got %b exp 0", exValid); end
    checks++; if (idReady !== 1'b0) begin errors++; $display("FAIL rst_idready got %b exp 0", idReady); end
    checks++; if ({srcA, srcB, exRd, funct3, useRegAdd, exTarget} !== '0) begin
      errors++; $display("FAIL rst_fields got %h exp 0", {srcA, srcB, exRd, funct3, useRegAdd, exTarget}); end
    tick();
    rstN = 1;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", idReady); end
    tick();
    checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b exp 0", exValid); end
  endtask

  task automatic test_add_raw();
    do_reset();
    idInstr = 32'h002081B3; idPc = 32'h40; rs1Data = 5; rs2Data = 7; idValid = 1;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", idReady); end
    checks++; if ({rs1Addr, rs2Addr} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL add_addr got %h exp %h", {rs1Addr, rs2Addr}, {5'd1, 5'd2}); end
    tick();
    idInstr = 32'h40118233; rs1Data = 9; rs2Data = 5;
    checks++; if ({exValid, funct3, useF7, funct7_60, exRd, exRegWrite} !== {1'b1, 3'd0, 1'b1, 2'b00, 5'd3, 1'b1}) begin
      errors++; $display("FAIL add_ctrl got %h exp %h", {exValid, funct3, useF7, funct7_60, exRd, exRegWrite},
                         {1'b1, 3'd0, 1'b1, 2'b00, 5'd3, 1'b1}); end
    checks++; if ({srcA, srcB} !== {32'd5, 32'd7}) begin
      errors++; $display("FAIL add_ops got %h exp %h", {srcA, srcB}, {32'd5, 32'd7}); end
    checks++; if (idReady !== 1'b0) begin errors++; $display("FAIL sub_stall got %b exp 0", idReady); end
    tick();
    checks++; if ({exValid, idReady} !== 2'b00) begin
      errors++; $display("FAIL sub_bubble got %b exp 00", {exValid, idReady}); end
    wbValid = 1; wbRd = 3; wbData = 32'h55;
    #1;
`ifdef ID_WB_BYPASS_EN
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL sub_wb_ready got %b exp 1", idReady); end
    tick();
    wbValid = 0; idValid = 0;
    checks++; if ({exValid, srcA, srcB, exRd, funct7_60} !== {1'b1, 32'h55, 32'd5, 5'd4, 2'b10}) begin
      errors++; $display("FAIL sub_issue got %h exp %h", {exValid, srcA, srcB, exRd, funct7_60},
                         {1'b1, 32'h55, 32'd5, 5'd4, 2'b10}); end
`else
    checks++; if (idReady !== 1'b0) begin errors++; $display("FAIL sub_wb_ready got %b exp 0", idReady); end
    tick();
    wbValid = 0;
    checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL sub_wb_bubble got %b exp 0", exValid); end
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL sub_late_ready got %b exp 1", idReady); end
    tick();
    idValid = 0;
    checks++; if ({exValid, srcA, srcB, exRd, funct7_60} !== {1'b1, 32'd9, 32'd5, 5'd4, 2'b10}) begin
      errors++; $display("FAIL sub_issue got %h exp %h", {exValid, srcA, srcB, exRd, funct7_60},
                         {1'b1, 32'd9, 32'd5, 5'd4, 2'b10}); end
`endif
  endtask

  task automatic test_branch();
    do_reset();
    idInstr = 32'hFE208CE3; idPc = 32'h100; rs1Data = 11; rs2Data = 22; idValid = 1;
    tick();
    idValid = 0;
    checks++; if ({exValid, branch, funct3, exRegWrite} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL beq_ctrl got %h exp %h", {exValid, branch, funct3, exRegWrite},
                         {1'b1, 1'b1, 3'd0, 1'b0}); end
    checks++; if ({srcA, srcB, exTarget} !== {32'd11, 32'd22, 32'h0F8}) begin
      errors++; $display("FAIL beq_ops got %h exp %h", {srcA, srcB, exTarget}, {32'd11, 32'd22, 32'h0F8}); end
  endtask

  task automatic test_jal_flush();
    do_reset();
    idInstr = 32'h010000EF; idPc = 32'h200; idValid = 1;
    tick();
    checks++; if ({srcA, srcB, exTarget, exRd, exRegWrite, useRegAdd} !== {32'h200, 32'd4, 32'h210, 5'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL jal_slot got %h exp %h", {srcA, srcB, exTarget, exRd, exRegWrite, useRegAdd},
                         {32'h200, 32'd4, 32'h210, 5'd1, 1'b1, 1'b1}); end
    idInstr = 32'h00100313; idPc = 32'h204; flush = 1;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", idReady); end
    tick();
    flush = 0; idValid = 0;
    checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL flush_bubble got %b exp 0", exValid); end
    idValid = 1; idInstr = 32'h00030393;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL flush_no_set got %b exp 1", idReady); end
    idInstr = 32'h00008413;
    #1;
    checks++; if (idReady !== 1'b0) begin errors++; $display("FAIL jal_pending got %b exp 0", idReady); end
    idValid = 0;
  endtask

  task automatic test_stall_reset();
    do_reset();
    idInstr = 32'h00500493; idValid = 1;
    tick();
    exReady = 0; idInstr = 32'h00100513;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({idReady, exValid, srcA, srcB, exRd, exRegWrite} !== {1'b0, 1'b1, 32'd0, 32'd5, 5'd9, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d got %h exp %h", c, {idReady, exValid, srcA, srcB, exRd, exRegWrite},
                           {1'b0, 1'b1, 32'd0, 32'd5, 5'd9, 1'b1}); end
      tick();
    end
    rstN = 0;
    #1;
    checks++; if ({exValid, idReady, exRd, srcB} !== '0) begin
      errors++; $display("FAIL stall_reset got %h exp 0", {exValid, idReady, exRd, srcB}); end
    idValid = 0; exReady = 1;
    tick();
    rstN = 1;
    #1;
    idValid = 1; idInstr = 32'h00048593;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL sb_cleared got %b exp 1", idReady); end
    idValid = 0;
  endtask

  task automatic test_lui_illegal();
    do_reset();
    idInstr = 32'h123452B7; idPc = 32'h300; idValid = 1;
    tick();
    checks++; if ({srcA, srcB, useRegAdd, funct3, exRegWrite, exRd} !== {32'd0, 32'h12345000, 1'b1, 3'd0, 1'b1, 5'd5}) begin
      errors++; $display("FAIL lui got %h exp %h", {srcA, srcB, useRegAdd, funct3, exRegWrite, exRd},
                         {32'd0, 32'h12345000, 1'b1, 3'd0, 1'b1, 5'd5}); end
    idInstr = 32'h0000037F;
    tick();
    idValid = 0;
    checks++; if ({exValid, exIllegal, exRegWrite} !== 3'b110) begin
      errors++; $display("FAIL illegal got %b exp 110", {exValid, exIllegal, exRegWrite}); end
    idValid = 1; idInstr = 32'h00030393;
    #1;
    checks++; if (idReady !== 1'b1) begin errors++; $display("FAIL illegal_no_sb got %b exp 1", idReady); end
    idValid = 0;
  endtask

  task automatic test_random();
    bit    pend[32];
    bit    pe[32];
    slot_t m, d, act;
    bit    m_valid, u1, u2, haz, adv, exp_rdy, iss, have;
    logic [31:0] r1, r2, pc;
    do_reset();
    foreach (pend[k]) pend[k] = 0;
    m = '0; m_valid = 0; have = 0;
    for (int c = 0; c < 600; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1;
        idInstr = rand_instr();
        pc = $urandom;
        idPc = pc & ~32'd3;
      end
      idValid = have;
      rs1Data = $urandom; rs2Data = $urandom;
      exReady = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      wbValid = ($urandom_range(0, 2) == 0);
      wbRd = 5'($urandom_range(0, 7));
      wbData = $urandom;
      #1;
      r1 = rs1Data; r2 = rs2Data;
      pe = pend;
`ifdef ID_WB_BYPASS_EN
      if (wbValid) pe[wbRd] = 0;
      if (wbValid && wbRd == idInstr[19:15] && wbRd != 0) r1 = wbData;
      if (wbValid && wbRd == idInstr[24:20] && wbRd != 0) r2 = wbData;
`endif
      ref_decode(idInstr, idPc, r1, r2, d, u1, u2);
      haz = (u1 && pe[idInstr[19:15]]) || (u2 && pe[idInstr[24:20]]) || (d.reg_write && pe[d.rd]);
      adv = !m_valid || exReady;
      exp_rdy = adv && (flush || !haz);
      iss = idValid && adv && !haz && !flush;
      checks++; if (idReady !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, idReady, exp_rdy); end
      if (wbValid) pend[wbRd] = 0;
      if (iss && d.reg_write) pend[d.rd] = 1;
      if (adv) begin
        m_valid = iss;
        if (iss) m = d;
      end
      if (idValid && exp_rdy) have = 0;
      tick();
      checks++; if (exValid !== m_valid) begin
        errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, exValid, m_valid); end
      if (m_valid) begin
        act = {exPc, srcA, srcB, exTarget, funct3, funct7_60, branch, csrOp, useF7, useRegAdd,
               exRd, exRegWrite, exIllegal};
        checks++; if (act !== m) begin
          errors++; $display("FAIL rnd_slot c%0d got %h exp %h", c, act, m); end
      end
    end
    idValid = 0; flush = 0; wbValid = 0; exReady = 1;
  endtask

  initial begin
    test_reset();
    test_add_raw();
    test_branch();
    test_jal_flush();
    test_stall_reset();
    test_lui_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue pipeline stage that drives the ALU's control and operand inputs: funct3, funct7_60, branch, csrOp, useF7, useRegAdd, srcA and srcB.
- Takes instructions from fetch over a valid/ready handshake and reads the register file combinationally.
- Tracks in-flight register writes in a scoreboard and stalls on RAW/WAW hazards.
- Holds one registered ID/EX slot, which EX drains with its own valid/ready handshake.

Parameters:
XLEN, 32, datapath width; all data/pc ports are XLEN wide
NREGS, 32, architectural registers; scoreboard width; x0 never tracked

Ports:
clk  in  1  clock, all state rising-edge
rstN  in  1  asynchronous active-low reset
idValid  in  1  fetch presents idInstr/idPc
idReady  out  1  stage accepts (issues or flushes) the current instruction this cycle
idInstr  in  32  RV32I instruction
idPc  in  XLEN  instruction address
rs1Addr  out  5  idInstr[19:15], combinational
rs2Addr  out  5  idInstr[24:20], combinational
rs1Data  in  XLEN  regfile read, same cycle
rs2Data  in  XLEN  regfile read, same cycle
exValid  out  1  ID/EX slot holds an instruction
exReady  in  1  EX consumes the slot this cycle
exPc  out  XLEN  registered pc
funct3  out  3  to ALU
funct7_60  out  2  {instr[30], instr[25]}
branch  out  1  opcode 1100011
csrOp  out  1  SYSTEM opcode with funct3 != 0
useF7  out  1  OP opcode, or OP-IMM with funct3=101
useRegAdd  out  1  LOAD/STORE/JAL/JALR/AUIPC/LUI; forces ALU add
srcA  out  XLEN  ALU operand A
srcB  out  XLEN  ALU operand B
exRd  out  5  destination register
exRegWrite  out  1  writes rd (rd != 0)
exTarget  out  XLEN  branch/JAL: pc+imm; JALR: (rs1+imm)&~1; else 0
exIllegal  out  1  unsupported opcode
wbValid  in  1  writeback retiring
wbRd  in  5  writeback register
wbData  in  XLEN  writeback value
flush  in  1  EX redirect; kill the instruction in decode

Behaviour:
- Reset (async, rstN=0): exValid=0, all ex*/ALU-control outputs 0, scoreboard all 0. idReady=0 while in reset.
- Slot advance: advance = !exValid | exReady.
- Hazard: rs1 used and pending[rs1], or rs2 used and pending[rs2], or regWrite and pending[rd]. Index 0 is never pending. rs2 is used only by OP, STORE and BRANCH; rs1 is unused by LUI, AUIPC and JAL.
- issue = idValid & advance & !hazard & !flush.
- idReady = advance & (flush | !hazard).
- Flush: the decode instruction is dropped (consumed, not issued). If advance, the slot loads a bubble (exValid=0).
- On issue, the slot loads the decoded fields next edge (latency 1) and exValid=1.
- If advance with no issue, exValid goes 0.
- If !advance, the slot holds all values stable.
- Operands:
  - srcA = pc for AUIPC/JAL/JALR; 0 for LUI; else rs1.
  - srcB = 4 for JAL/JALR; rs2 for OP/BRANCH; else imm (I/S/U per format, sign-extended).
  - funct3 = 0 for LUI/AUIPC/JAL.
- Scoreboard:
  - On issue with regWrite, set pending[rd].
  - On wbValid, clear pending[wbRd].
  - Same cycle, same index: set wins.
- exIllegal=1: exRegWrite=0, no scoreboard set, and instruction still issues so EX can trap.
- Reset mid-stall: all state clears; fetch must re-present.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - A register being cleared by wbValid in the same cycle is not treated as pending.
  - rs1Data/rs2Data for that index are replaced by wbData (rd != 0).
  - Saves one stall cycle.
- Undefined:
  - Hazard uses registered pending only; issue waits one cycle after writeback.
  - wbData is unused.

Decomposition:
- Shared core package holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - an immediate-format enum;
  - an id_ex_t struct for the slot.
- Sub-module imm_gen: combinational sign-extended immediate from instr and format. Everything else stays in id_issue_stage.

Test Plan:
- Fetch `add x3,x1,x2` (0x002081B3) with rs1Data=5, rs2Data=7, exReady=1 -> next cycle:
  - exValid=1, funct3=0, useF7=1, funct7_60=00, srcA=5, srcB=7, exRd=3;
  - pending[3]=1.
- `sub x4,x3,x1` right after the add, no writeback -> idReady=0 and exValid=0 bubble. Then wbValid with wbRd=3 at cycle N:
  - bypass macro defined: issue at N;
  - undefined: issue at N+1.
- `beq x1,x2,-8` at pc=0x100 -> branch=1, funct3=000, srcB=rs2Data, exTarget=0x0F8, exRegWrite=0.
- `jal x1,+16` at pc=0x200, then flush asserted with the next instruction in decode -> JAL slot has srcA=0x200, srcB=4, exTarget=0x210. Flushed instruction is consumed (idReady=1), exValid=0 after, pending unchanged.
- exReady=0 for 3 cycles with a valid slot -> all ex outputs stable, idReady=0. Then rstN=0 -> exValid=0 immediately and scoreboard cleared.
- `lui x5,0x12345` -> srcA=0, srcB=0x12345000, useRegAdd=1. Opcode 0x7F -> exIllegal=1, exRegWrite=0.
